// File: rtl/btn_pkg.sv
// ---------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the push-button conditioning stage.
//   NUM_BTN      : number of board buttons handled
//   rep_state_t  : per-button auto-repeat FSM states
//   cnt_width()  : counter width for a terminal count (never below 1 bit)
// ---------------------------------------------------------------------------
package btn_pkg;

  localparam int NUM_BTN = 4;

  typedef enum logic [1:0] {
    R_IDLE,
    R_HOLD,
    R_DELAY,
    R_REPEAT
  } rep_state_t;

  // Width of a counter that runs 0..n-1; $clog2(1) is 0, so clamp to 1.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// ---------------------------------------------------------------------------
// btn_conditioner_if
// Button bundle between the board buttons and the controller.
//   btn_raw   : asynchronous raw buttons, active-high (into the conditioner)
//   btn_level : debounced button levels
//   btn_pulse : one-cycle press pulses, including auto-repeats
//   tick      : one-cycle periodic count-enable strobe
// Modports: master = driver of the buttons / consumer of the results,
//           slave  = the conditioner itself.
// ---------------------------------------------------------------------------
interface btn_conditioner_if;
  import btn_pkg::*;

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_pulse;
  logic               tick;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_pulse,
    input  tick
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_pulse,
    output tick
  );

endinterface

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// One button: 2-flop synchroniser, counter-based debounce and a press-pulse
// generator with optional auto-repeat.
//   clk      : system clock
//   rst      : asynchronous, active-high reset
//   raw_i    : asynchronous raw button, active-high
//   level_o  : debounced level (registered)
//   pulse_o  : one-cycle press / repeat pulse (registered)
// ---------------------------------------------------------------------------
module btn_debounce
  import btn_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 1_250_000,
  parameter int   REPEAT_DELAY    = 62_500_000,
  parameter int   REPEAT_PERIOD   = 25_000_000,
  parameter logic REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic pulse_o
);

  localparam int DC_W = cnt_width(DEBOUNCE_CYCLES);
  localparam int RC_W = (cnt_width(REPEAT_DELAY) > cnt_width(REPEAT_PERIOD)) ?
                        cnt_width(REPEAT_DELAY) : cnt_width(REPEAT_PERIOD);

  localparam logic [DC_W-1:0] DC_LAST    = DC_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RC_W-1:0] DELAY_LAST = RC_W'(REPEAT_DELAY - 1);
  localparam logic [RC_W-1:0] PER_LAST   = RC_W'(REPEAT_PERIOD - 1);

  logic            meta_q;
  logic            sync_q;
  logic [DC_W-1:0] dc_q, dc_d;
  logic            level_q, level_d;
  rep_state_t      state_q;
  logic [RC_W-1:0] rc_q;
  logic            pulse_q;

  // NOTE: always_comb must assign every output on every path before any
  // conditional logic, otherwise synthesis infers a latch to hold the value.
  always_comb begin
    level_d = level_q;
    dc_d    = '0;
    if (sync_q != level_q) begin
      if (dc_q == DC_LAST) begin
        level_d = sync_q;
      end else begin
        dc_d = dc_q + DC_W'(1);
      end
    end
  end

  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would chain the synchroniser into one flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      dc_q    <= '0;
      level_q <= 1'b0;
    end else begin
      meta_q  <= raw_i;
      sync_q  <= meta_q;
      dc_q    <= dc_d;
      level_q <= level_d;
    end
  end

  // The FSM looks at level_d so the press pulse registers on the same edge
  // the debounced level rises, and a release on the edge a repeat would fire
  // suppresses that repeat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= R_IDLE;
      rc_q    <= '0;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        R_IDLE: begin
          if (level_d && !level_q) begin
            pulse_q <= 1'b1;
            state_q <= REPEAT_EN ? R_DELAY : R_HOLD;
            rc_q    <= '0;
          end
        end
        R_HOLD: begin
          if (!level_d) state_q <= R_IDLE;
        end
        R_DELAY: begin
          if (!level_d) begin
            state_q <= R_IDLE;
            rc_q    <= '0;
          end else if (rc_q == DELAY_LAST) begin
            pulse_q <= 1'b1;
            state_q <= R_REPEAT;
            rc_q    <= '0;
          end else begin
            rc_q <= rc_q + RC_W'(1);
          end
        end
        R_REPEAT: begin
          if (!level_d) begin
            state_q <= R_IDLE;
            rc_q    <= '0;
          end else if (rc_q == PER_LAST) begin
            pulse_q <= 1'b1;
            rc_q    <= '0;
          end else begin
            rc_q <= rc_q + RC_W'(1);
          end
        end
        default: begin
          state_q <= R_IDLE;
          rc_q    <= '0;
        end
      endcase
    end
  end

  assign level_o = level_q;
  assign pulse_o = pulse_q;

endmodule

// File: rtl/btn_conditioner.sv
// ---------------------------------------------------------------------------
// btn_conditioner
// Front-end conditioning for the board push-buttons plus the periodic tick
// used as the controller's count enable. All outputs registered in clk.
//   clk  : system clock
//   rst  : asynchronous, active-high reset
//   bus  : btn_conditioner_if.slave
//            btn_raw   in  NUM_BTN  raw buttons
//            btn_level out NUM_BTN  debounced levels
//            btn_pulse out NUM_BTN  press / repeat pulses
//            tick      out 1        strobe every TICK_CYCLES cycles
// ---------------------------------------------------------------------------
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int                 DEBOUNCE_CYCLES = 1_250_000,
  parameter int                 REPEAT_DELAY    = 62_500_000,
  parameter int                 REPEAT_PERIOD   = 25_000_000,
  parameter logic [NUM_BTN-1:0] REPEAT_EN       = 4'b0001,
  parameter int                 TICK_CYCLES     = 125_000_000
) (
  input logic               clk,
  input logic               rst,
  btn_conditioner_if.slave  bus
);

  localparam int              TC_W    = cnt_width(TICK_CYCLES);
  localparam logic [TC_W-1:0] TC_LAST = TC_W'(TICK_CYCLES - 1);

  logic [NUM_BTN-1:0] level_w;
  logic [NUM_BTN-1:0] pulse_w;
  logic [TC_W-1:0]    tc_q;
  logic               tick_q;

  // Buttons are independent; each gets its own conditioner.
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .REPEAT_EN       (REPEAT_EN[i])
    ) u_btn (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (bus.btn_raw[i]),
      .level_o (level_w[i]),
      .pulse_o (pulse_w[i])
    );
  end

  // Free-running tick: the strobe is the registered terminal-count compare,
  // so it is high in the cycle after tc reaches TICK_CYCLES-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tc_q   <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= (tc_q == TC_LAST);
      tc_q   <= (tc_q == TC_LAST) ? '0 : tc_q + TC_W'(1);
    end
  end

  assign bus.btn_level = level_w;
  assign bus.btn_pulse = pulse_w;
  assign bus.tick      = tick_q;

endmodule
